// File: rtl/jtcontra_colmix_pkg.sv
// Shared types and constants for the jtcontra colour mixer.
// Palette words are 15-bit BGR 5:5:5 split into a lo byte {G[2:0], R[4:0]}
// and a hi byte {x, B[4:0], G[4:3]}.
package jtcontra_colmix_pkg;

  localparam int PAL_ENTRIES = 128;
  localparam int IDX_W       = 7;

  typedef struct packed {
    logic [4:0] blue;
    logic [4:0] green;
    logic [4:0] red;
  } rgb555_t;

  // FSM encoding
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // Byte bit-field positions
  localparam int LO_R_LSB = 0;
  localparam int LO_G_LSB = 5;
  localparam int HI_G_LSB = 0;
  localparam int HI_B_LSB = 2;

  function automatic rgb555_t pal_unpack(input logic [7:0] hi, input logic [7:0] lo);
    rgb555_t c;
    c.red   = lo[LO_R_LSB +: 5];
    c.green = {hi[HI_G_LSB +: 2], lo[LO_G_LSB +: 3]};
    c.blue  = hi[HI_B_LSB +: 5];
    return c;
  endfunction

endpackage

// File: rtl/jtcontra_colmix_prio.sv
// Layer selection between the back (gfx1) and front (gfx2) 007121 outputs.
// Pixel format: {pal_bank[1:0], tile_n_obj, colour[3:0]}. Purely combinational.
module jtcontra_colmix_prio
  import jtcontra_colmix_pkg::*;
(
  input  logic [6:0]       gfx1_pxl,
  input  logic [6:0]       gfx2_pxl,
  input  logic             prio,
  output logic [IDX_W-1:0] pal_idx
);

  logic       gfx2_blank;
  logic       gfx1_obj;
  logic [6:0] sel;

  assign gfx2_blank = (gfx2_pxl[3:0] == 4'd0);
  assign gfx1_obj   = ~gfx1_pxl[4] & (gfx1_pxl[3:0] != 4'd0);
  assign sel        = (gfx2_blank | (prio & gfx1_obj)) ? gfx1_pxl : gfx2_pxl;
  assign pal_idx    = {sel[6:5], sel[4], sel[3:0]};

endmodule

// File: rtl/jtframe_dual_ram.sv
// Dual-port RAM, both ports synchronous on one clock with registered reads.
// Simultaneous writes to the same address: port 1 wins.
// A read of an address being written returns the old contents.
module jtframe_dual_ram #(
  parameter int dw = 8,
  parameter int aw = 7
) (
  input  logic          clk,
  input  logic [dw-1:0] data0,
  input  logic [aw-1:0] addr0,
  input  logic          we0,
  output logic [dw-1:0] q0,
  input  logic [dw-1:0] data1,
  input  logic [aw-1:0] addr1,
  input  logic          we1,
  output logic [dw-1:0] q1
);

  logic [dw-1:0] mem [0:(2**aw)-1];

  // Registered reads and writes for both ports
  always_ff @(posedge clk) begin
    q0 <= mem[addr0];
    q1 <= mem[addr1];
    if (we0) mem[addr0] <= data0;
    if (we1) mem[addr1] <= data1;
  end

endmodule

// File: rtl/jtcontra_colmix.sv
// Colour mixer: picks the visible 007121 pixel, looks it up in the CPU
// palette and drives RGB with blanking delayed to match the pipeline.
// Optional macro JTCONTRA_PAL_READBACK_EN enables CPU palette reads;
// without it pal_dout reads as 0xFF and the CPU-side read data is unused.
//
// state    | meaning
// ST_CLEAR | sweep writes 0 to every palette index, CPU blocked, RGB blanked
// ST_RUN   | normal operation, CPU owns palette port 0; left only via rst
module jtcontra_colmix
  import jtcontra_colmix_pkg::*;
#(
  parameter int BLANK_DLY = 2,
  parameter int PAL_AW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pxl_cen,
  input  logic              LHBL,
  input  logic              LVBL,
  input  logic              cpu_cen,
  input  logic              pal_cs,
  input  logic              cpu_rnw,
  input  logic [PAL_AW-1:0] cpu_addr,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        pal_dout,
  input  logic [6:0]        gfx1_pxl,
  input  logic [6:0]        gfx2_pxl,
  input  logic              prio,
  output logic              clr_busy,
  output logic [4:0]        red,
  output logic [4:0]        green,
  output logic [4:0]        blue,
  output logic              LHBL_dly,
  output logic              LVBL_dly
);

  localparam int                RAM_AW   = PAL_AW - 1;
  localparam logic [RAM_AW-1:0] CLR_LAST = RAM_AW'(PAL_ENTRIES - 1);

  logic [0:0]           st;
  logic [RAM_AW-1:0]    clr_addr;
  logic [IDX_W-1:0]     pxl_idx;
  logic [RAM_AW-1:0]    vid_addr;
  logic [7:0]           vid_lo, vid_hi;
  rgb555_t              pal_rgb;
  logic [BLANK_DLY-1:0] hbl_sr, vbl_sr;
  logic                 cpu_wr, we_lo, we_hi, visible;
  logic [RAM_AW-1:0]    addr0;
  logic [7:0]           data0;

  jtcontra_colmix_prio u_prio (
    .gfx1_pxl (gfx1_pxl),
    .gfx2_pxl (gfx2_pxl),
    .prio     (prio),
    .pal_idx  (pxl_idx)
  );

  // Clear sweep: one index per clk, then hand port 0 to the CPU
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_CLEAR;
      clr_addr <= '0;
    end else if (st == ST_CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == CLR_LAST) st <= ST_RUN;
    end
  end

  assign clr_busy = (st == ST_CLEAR);

  // Port 0 is shared between the sweep and the CPU; CPU writes are ignored while clearing
  assign cpu_wr = pal_cs & ~cpu_rnw & cpu_cen & ~clr_busy;
  assign addr0  = clr_busy ? clr_addr : cpu_addr[PAL_AW-1:1];
  assign data0  = clr_busy ? 8'h00 : cpu_dout;
  assign we_lo  = clr_busy | (cpu_wr & ~cpu_addr[0]);
  assign we_hi  = clr_busy | (cpu_wr &  cpu_addr[0]);

`ifdef JTCONTRA_PAL_READBACK_EN
  logic [7:0] lo_q0, hi_q0;
  logic       rd_hi, rd_ok;

  // Track which byte lane was addressed and whether the palette was valid then
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_hi <= 1'b0;
      rd_ok <= 1'b0;
    end else begin
      rd_hi <= cpu_addr[0];
      rd_ok <= ~clr_busy;
    end
  end

  assign pal_dout = !rd_ok ? 8'h00 : (rd_hi ? hi_q0 : lo_q0);
`else
  assign pal_dout = 8'hFF;
`endif

  jtframe_dual_ram #(.dw(8), .aw(RAM_AW)) u_ram_lo (
    .clk   (clk),
    .data0 (data0),
    .addr0 (addr0),
    .we0   (we_lo),
`ifdef JTCONTRA_PAL_READBACK_EN
    .q0    (lo_q0),
`else
    .q0    (),
`endif
    .data1 (8'h00),
    .addr1 (vid_addr),
    .we1   (1'b0),
    .q1    (vid_lo)
  );

  jtframe_dual_ram #(.dw(8), .aw(RAM_AW)) u_ram_hi (
    .clk   (clk),
    .data0 (data0),
    .addr0 (addr0),
    .we0   (we_hi),
`ifdef JTCONTRA_PAL_READBACK_EN
    .q0    (hi_q0),
`else
    .q0    (),
`endif
    .data1 (8'h00),
    .addr1 (vid_addr),
    .we1   (1'b0),
    .q1    (vid_hi)
  );

  // Two-tick video pipeline: latch index, then latch RAM word; blanking follows in step
  always_ff @(posedge clk) begin
    if (rst) begin
      vid_addr <= '0;
      pal_rgb  <= '0;
      hbl_sr   <= '0;
      vbl_sr   <= '0;
    end else if (pxl_cen) begin
      vid_addr <= RAM_AW'(pxl_idx);
      pal_rgb  <= pal_unpack(vid_hi, vid_lo);
      hbl_sr   <= BLANK_DLY'({hbl_sr, LHBL});
      vbl_sr   <= BLANK_DLY'({vbl_sr, LVBL});
    end
  end

  assign LHBL_dly = hbl_sr[BLANK_DLY-1];
  assign LVBL_dly = vbl_sr[BLANK_DLY-1];
  assign visible  = LHBL_dly & LVBL_dly & ~clr_busy;
  assign red      = visible ? pal_rgb.red   : 5'd0;
  assign green    = visible ? pal_rgb.green : 5'd0;
  assign blue     = visible ? pal_rgb.blue  : 5'd0;

endmodule

// File: tb/tb_jtcontra_colmix.sv
// Directed bench for jtcontra_colmix. Expected CPU read data follows
// JTCONTRA_PAL_READBACK_EN: palette contents when defined, 0xFF otherwise.
module tb_jtcontra_colmix;

  logic       clk, rst, pxl_cen, LHBL, LVBL, cpu_cen, pal_cs, cpu_rnw, prio;
  logic [7:0] cpu_addr, cpu_dout, pal_dout;
  logic [6:0] gfx1_pxl, gfx2_pxl;
  logic       clr_busy, LHBL_dly, LVBL_dly;
  logic [4:0] red, green, blue;

  int vec_n  = 0;
  int miss_n = 0;

  jtcontra_colmix #(.BLANK_DLY(2), .PAL_AW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .cpu_cen  (cpu_cen),
    .pal_cs   (pal_cs),
    .cpu_rnw  (cpu_rnw),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .pal_dout (pal_dout),
    .gfx1_pxl (gfx1_pxl),
    .gfx2_pxl (gfx2_pxl),
    .prio     (prio),
    .clr_busy (clr_busy),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .LHBL_dly (LHBL_dly),
    .LVBL_dly (LVBL_dly)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_rd(input logic [7:0] v);
`ifdef JTCONTRA_PAL_READBACK_EN
    return v;
`else
    return 8'hFF;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_n++;
    assert (obs === exp) else begin
      miss_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rgb(input string tag, input logic [4:0] r, input logic [4:0] g,
                           input logic [4:0] b);
    check(tag, {17'd0, red, green, blue}, {17'd0, r, g, b});
  endtask

  task automatic tick();
    @(negedge clk) pxl_cen = 1'b1;
    @(negedge clk) pxl_cen = 1'b0;
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_cen = 1'b1; cpu_addr = a; cpu_dout = d;
    @(negedge clk);
    pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_cen = 1'b1; cpu_addr = a;
    @(negedge clk);
    d = pal_dout;
    pal_cs = 1'b0; cpu_cen = 1'b0;
  endtask

  task automatic show(input logic [6:0] g1, input logic [6:0] g2, input logic p);
    @(negedge clk);
    gfx1_pxl = g1; gfx2_pxl = g2; prio = p;
    tick();
    tick();
  endtask

  initial begin
    logic [7:0] rd;
    int         n;
    logic       rgb_seen;

    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
    cpu_cen = 1'b0; pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_addr = 8'h00; cpu_dout = 8'h00;
    gfx1_pxl = 7'h00; gfx2_pxl = 7'h00; prio = 1'b0;

    repeat (3) @(negedge clk);
    check_rgb("rst_rgb", 5'd0, 5'd0, 5'd0);
    check("rst_blank", {30'd0, LHBL_dly, LVBL_dly}, 32'd0);
    check("rst_busy", {31'd0, clr_busy}, 32'd1);
    check("rst_dout", {24'd0, pal_dout}, {24'd0, exp_rd(8'h00)});

    // Start a sweep, interrupt it at index 60
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("busy_mid", {31'd0, clr_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Full restarted sweep, with a CPU write to index 10 attempted mid-way
    n = 0;
    rgb_seen = 1'b0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      pxl_cen = n[0];
      if (n == 100) begin
        pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_cen = 1'b1; cpu_addr = 8'h14; cpu_dout = 8'hAA;
      end
      if (n == 101) cpu_addr = 8'h15;
      if (n == 102) begin
        pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0;
      end
      if ({red, green, blue} != 15'd0) rgb_seen = 1'b1;
      if (!clr_busy) break;
    end
    pxl_cen = 1'b0; pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0;
    check("sweep_len", n, 32'd128);
    check("sweep_rgb", {31'd0, rgb_seen}, 32'd0);

    cpu_read(8'h55, rd);
    check("rd_55", {24'd0, rd}, {24'd0, exp_rd(8'h00)});
    cpu_read(8'h14, rd);
    check("clr_wr_drop", {24'd0, rd}, {24'd0, exp_rd(8'h00)});

    // Palette: idx1 R31 G0 B31, idx2 R5 G10 B20, idx5 G31, idx19 R1 G2 B3
    cpu_write(8'h02, 8'h1F); cpu_write(8'h03, 8'h7C);
    cpu_write(8'h04, 8'h45); cpu_write(8'h05, 8'h51);
    cpu_write(8'h0A, 8'hE0); cpu_write(8'h0B, 8'h03);
    cpu_write(8'h26, 8'h41); cpu_write(8'h27, 8'h0C);
    cpu_read(8'h03, rd);
    check("rd_03", {24'd0, rd}, {24'd0, exp_rd(8'h7C)});
    cpu_read(8'h04, rd);
    check("rd_04", {24'd0, rd}, {24'd0, exp_rd(8'h45)});

    // Latency: one tick after the new pixel the old (index 0) colour is still out
    @(negedge clk);
    gfx1_pxl = 7'h10; gfx2_pxl = 7'h01; prio = 1'b0;
    tick();
    check_rgb("lat_1tick", 5'd0, 5'd0, 5'd0);
    tick();
    check_rgb("g2_idx1", 5'd31, 5'd0, 5'd31);

    show(7'h05, 7'h10, 1'b0);
    check_rgb("g2_transp", 5'd0, 5'd31, 5'd0);
    show(7'h02, 7'h13, 1'b1);
    check_rgb("prio_obj", 5'd5, 5'd10, 5'd20);
    show(7'h02, 7'h13, 1'b0);
    check_rgb("noprio", 5'd1, 5'd2, 5'd3);
    show(7'h12, 7'h13, 1'b1);
    check_rgb("prio_tile", 5'd1, 5'd2, 5'd3);
    show(7'h00, 7'h13, 1'b1);
    check_rgb("prio_c0", 5'd1, 5'd2, 5'd3);
    show(7'h05, 7'h40, 1'b0);
    check_rgb("g2_bank_transp", 5'd0, 5'd31, 5'd0);
    show(7'h00, 7'h0A, 1'b0);
    check_rgb("clr_wr_vid", 5'd0, 5'd0, 5'd0);

    // Horizontal blank pulse of one tick
    show(7'h10, 7'h01, 1'b0);
    LHBL = 1'b0;
    tick();
    LHBL = 1'b1;
    check("hbl_t1", {31'd0, LHBL_dly}, 32'd1);
    check_rgb("hbl_t1_rgb", 5'd31, 5'd0, 5'd31);
    tick();
    check("hbl_t2", {31'd0, LHBL_dly}, 32'd0);
    check_rgb("hbl_t2_rgb", 5'd0, 5'd0, 5'd0);
    tick();
    check("hbl_t3", {31'd0, LHBL_dly}, 32'd1);
    check_rgb("hbl_t3_rgb", 5'd31, 5'd0, 5'd31);

    // Vertical blank pulse of one tick
    LVBL = 1'b0;
    tick();
    LVBL = 1'b1;
    tick();
    check("vbl_t2", {31'd0, LVBL_dly}, 32'd0);
    check_rgb("vbl_t2_rgb", 5'd0, 5'd0, 5'd0);
    tick();
    check("vbl_t3", {31'd0, LVBL_dly}, 32'd1);

    // Freeze: no pxl_cen, pixel input changes, CPU rewrites idx1 red to 16
    gfx1_pxl = 7'h05; gfx2_pxl = 7'h10;
    LHBL = 1'b0;
    cpu_write(8'h02, 8'h10);
    repeat (10) @(negedge clk);
    check_rgb("freeze_rgb", 5'd31, 5'd0, 5'd31);
    check("freeze_hbl", {31'd0, LHBL_dly}, 32'd1);
    LHBL = 1'b1;
    show(7'h10, 7'h01, 1'b0);
    check_rgb("cpu_upd", 5'd16, 5'd0, 5'd31);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule
